// File: rtl/trigger_buffer_manager_n_pkg.sv
// rtl/trigger_buffer_manager_n_pkg.sv - shared constants and FSM encoding for the trigger buffer manager
package trigger_pkg;

  // Trigger source bit positions within trig_i / src_en_i
  localparam int SRC_RF   = 0;
  localparam int SRC_PPS1 = 1;
  localparam int SRC_PPS2 = 2;
  localparam int SRC_SOFT = 3;

  // Default sizing
  localparam int DEF_NUM_BUF      = 4;
  localparam int DEF_BUF_BITS     = 2;
  localparam int DEF_NUM_SRC      = 4;
  localparam int DEF_HOLDOFF_BITS = 8;
  localparam int DEF_LOST_BITS    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_e;

endpackage

// File: rtl/trigger_buffer_manager_n_rr_free_finder.sv
// rtl/trigger_buffer_manager_n_rr_free_finder.sv - round-robin search for the first free buffer
module rr_free_finder
  import trigger_pkg::*;
#(
  parameter int NUM_BUF  = DEF_NUM_BUF,
  parameter int BUF_BITS = DEF_BUF_BITS
) (
  input  logic [NUM_BUF-1:0]  status,
  input  logic [BUF_BITS-1:0] start,
  output logic [BUF_BITS-1:0] idx,
  output logic                found
);

  logic [NUM_BUF-1:0] rotated;
  logic [BUF_BITS:0]  sum;

  // Rotate status so bit 0 is the buffer at start, then take the lowest clear bit
  always_comb begin
    rotated = NUM_BUF'({status, status} >> start);
    found   = 1'b0;
    sum     = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (!rotated[i]) begin
        sum   = {1'b0, start} + (BUF_BITS + 1)'(i);
        found = 1'b1;
      end
    end
    if (sum >= (BUF_BITS + 1)'(NUM_BUF)) begin
      sum = sum - (BUF_BITS + 1)'(NUM_BUF);
    end
    idx = sum[BUF_BITS-1:0];
  end

endmodule

// File: rtl/trigger_buffer_manager_n.sv
// rtl/trigger_buffer_manager_n.sv - masked trigger intake, round-robin buffer allocation and hold control
module trigger_buffer_manager_n
  import trigger_pkg::*;
#(
  parameter int NUM_BUF      = DEF_NUM_BUF,
  parameter int BUF_BITS     = DEF_BUF_BITS,
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int HOLDOFF_BITS = DEF_HOLDOFF_BITS,
  parameter int LOST_BITS    = DEF_LOST_BITS
) (
  input  logic                    clk250_i,
  input  logic                    rst_i,
  input  logic [NUM_SRC-1:0]      trig_i,
  input  logic [NUM_SRC-1:0]      src_en_i,
  input  logic                    disable_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    clear_i,
  input  logic [BUF_BITS-1:0]     clear_buffer_i,
  input  logic                    lost_clr_i,
  output logic                    digitize_o,
  output logic [BUF_BITS-1:0]     digitize_buffer_o,
  output logic [NUM_SRC-1:0]      digitize_source_o,
  output logic [NUM_BUF-1:0]      buffer_status_o,
  output logic [NUM_BUF-1:0]      HOLD_o,
  output logic                    dead_o,
  output logic [LOST_BITS-1:0]    lost_count_o
);

  trig_state_e             state;
  trig_state_e             state_next;
  logic [BUF_BITS-1:0]     wr_ptr;
  logic [BUF_BITS-1:0]     free_idx;
  logic                    free_found;
  logic [NUM_SRC-1:0]      masked;
  logic                    trig_event;
  logic                    accept;
  logic [HOLDOFF_BITS-1:0] holdoff_cnt;
  logic [NUM_BUF-1:0]      one_hot_base;
  logic [NUM_BUF-1:0]      set_mask;
  logic [NUM_BUF-1:0]      clr_mask;

  rr_free_finder #(
    .NUM_BUF  (NUM_BUF),
    .BUF_BITS (BUF_BITS)
  ) u_finder (
    .status (buffer_status_o),
    .start  (wr_ptr),
    .idx    (free_idx),
    .found  (free_found)
  );

  assign masked       = trig_i & src_en_i & {NUM_SRC{~disable_i}};
  assign trig_event   = |masked;
  assign accept       = (state == IDLE) && trig_event && free_found;
  assign one_hot_base = NUM_BUF'(1);
  // Shifting past the top bit yields zero, so out-of-range clear indices drop out
  assign set_mask     = accept  ? (one_hot_base << free_idx)       : '0;
  assign clr_mask     = clear_i ? (one_hot_base << clear_buffer_i) : '0;
  assign dead_o       = (state != IDLE) | (&buffer_status_o) | disable_i;
  assign HOLD_o       = buffer_status_o;

  // FSM state register
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: one ISSUE cycle, then optional holdoff dead time
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = (holdoff_i == '0) ? IDLE : HOLDOFF;
      HOLDOFF: if (holdoff_cnt == HOLDOFF_BITS'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Holdoff counter: loaded while issuing, counts down through HOLDOFF
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      holdoff_cnt <= '0;
    end else if (state == ISSUE) begin
      holdoff_cnt <= holdoff_i;
    end else if (state == HOLDOFF) begin
      holdoff_cnt <= holdoff_cnt - HOLDOFF_BITS'(1);
    end
  end

  // Occupancy and round-robin pointer; an allocation beats a clear of the same buffer
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      buffer_status_o <= '0;
      wr_ptr          <= '0;
    end else begin
      buffer_status_o <= (buffer_status_o & ~clr_mask) | set_mask;
      if (accept) begin
        wr_ptr <= (free_idx == BUF_BITS'(NUM_BUF - 1)) ? '0 : free_idx + BUF_BITS'(1);
      end
    end
  end

  // Registered digitize command, high for the single ISSUE cycle
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      digitize_o        <= 1'b0;
      digitize_buffer_o <= '0;
      digitize_source_o <= '0;
    end else begin
      digitize_o        <= accept;
      digitize_buffer_o <= accept ? free_idx : '0;
      digitize_source_o <= accept ? masked : '0;
    end
  end

  // Saturating count of qualified triggers that could not be accepted
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      lost_count_o <= '0;
    end else if (lost_clr_i) begin
      lost_count_o <= '0;
    end else if (trig_event && !accept && (lost_count_o != '1)) begin
      lost_count_o <= lost_count_o + LOST_BITS'(1);
    end
  end

endmodule

// File: tb/tb_trigger_buffer_manager_n.sv
// tb/tb_trigger_buffer_manager_n.sv - self-checking bench for trigger_buffer_manager_n
module tb_trigger_buffer_manager_n;

  localparam int NB = 4;
  localparam int BB = 2;
  localparam int NS = 4;
  localparam int HB = 8;
  localparam int LB = 16;

  logic          clk250     = 1'b0;
  logic          rst_i      = 1'b0;
  logic [NS-1:0] trig       = '0;
  logic [NS-1:0] src_en     = '1;
  logic          disable_in = 1'b0;
  logic [HB-1:0] holdoff    = '0;
  logic          clear      = 1'b0;
  logic [BB-1:0] clear_buf  = '0;
  logic          lost_clr   = 1'b0;

  logic          digitize;
  logic [BB-1:0] dig_buf;
  logic [NS-1:0] dig_src;
  logic [NB-1:0] status;
  logic [NB-1:0] hold;
  logic          dead;
  logic [LB-1:0] lost_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Reference model state
  logic [NB-1:0] occ       = '0;
  int            ptr       = 0;
  int            busy      = 0;
  bit            need_hold = 0;
  bit            exp_dig   = 0;
  int            exp_buf   = 0;
  int            exp_src   = 0;
  int            lost      = 0;

  trigger_buffer_manager_n dut (
    .clk250_i          (clk250),
    .rst_i             (rst_i),
    .trig_i            (trig),
    .src_en_i          (src_en),
    .disable_i         (disable_in),
    .holdoff_i         (holdoff),
    .clear_i           (clear),
    .clear_buffer_i    (clear_buf),
    .lost_clr_i        (lost_clr),
    .digitize_o        (digitize),
    .digitize_buffer_o (dig_buf),
    .digitize_source_o (dig_src),
    .buffer_status_o   (status),
    .HOLD_o            (hold),
    .dead_o            (dead),
    .lost_count_o      (lost_count)
  );

  always #5 clk250 = ~clk250;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: busy counts remaining non-idle cycles; holdoff is added when the issue cycle ends
  always @(posedge clk250 or posedge rst_i) begin
    int  m;
    int  b;
    bit  found;
    bit  acc;
    if (rst_i) begin
      occ = '0; ptr = 0; busy = 0; need_hold = 0;
      exp_dig = 0; exp_buf = 0; exp_src = 0; lost = 0;
    end else begin
      m = disable_in ? 0 : int'(trig & src_en);
      found = 0;
      b = 0;
      for (int k = 0; k < NB; k++) begin
        if (!found && !occ[(ptr + k) % NB]) begin
          found = 1;
          b = (ptr + k) % NB;
        end
      end
      acc = (m != 0) && (busy == 0) && found;
      if (busy > 0) busy--;
      if (need_hold) begin
        busy += int'(holdoff);
        need_hold = 0;
      end
      if (acc) begin
        busy = 1;
        need_hold = 1;
      end
      if (clear && int'(clear_buf) < NB && !(acc && int'(clear_buf) == b)) occ[clear_buf] = 1'b0;
      if (acc) begin
        occ[b] = 1'b1;
        ptr = (b + 1) % NB;
      end
      exp_dig = acc;
      exp_buf = b;
      exp_src = m;
      if (lost_clr) lost = 0;
      else if (m != 0 && !acc && lost < 65535) lost++;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk250) begin
    if (chk_en) begin
      check("digitize", digitize, exp_dig);
      if (exp_dig) begin
        check("dig_buf", dig_buf, exp_buf);
        check("dig_src", dig_src, exp_src);
      end
      check("status", status, occ);
      check("hold", hold, occ);
      check("dead", dead, (busy != 0) || (&occ) || disable_in);
      check("lost", lost_count, lost);
    end
  end

  task automatic tick();
    @(posedge clk250);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic fire(input logic [NS-1:0] t);
    trig = t;
    tick();
    trig = '0;
  endtask

  initial begin
    #1 rst_i = 1'b1;
    chk_en = 1;
    tick();
    tick();
    @(negedge clk250);
    check("rst_digitize", digitize, 0);
    check("rst_status", status, 0);
    check("rst_lost", lost_count, 0);
    tick();
    rst_i = 1'b0;

    // First trigger lands in buffer 0
    holdoff = 0;
    fire(4'b0001);
    @(negedge clk250);
    check("t1_digitize", digitize, 1);
    check("t1_buf", dig_buf, 0);
    check("t1_src", dig_src, 4'b0001);
    check("t1_hold", hold, 4'b0001);
    check("t1_lost", lost_count, 0);
    tick();

    // Round-robin fill, overflow, clear and reuse
    do_reset();
    for (int i = 0; i < NB; i++) begin
      fire(4'b0001);
      @(negedge clk250);
      check("rr_digitize", digitize, 1);
      check("rr_buf", dig_buf, i);
      tick();
      tick();
    end
    fire(4'b0001);
    @(negedge clk250);
    check("full_digitize", digitize, 0);
    check("full_dead", dead, 1);
    check("full_lost", lost_count, 1);
    tick();
    clear = 1'b1;
    clear_buf = 2'd2;
    tick();
    clear = 1'b0;
    fire(4'b0001);
    @(negedge clk250);
    check("reuse_digitize", digitize, 1);
    check("reuse_buf", dig_buf, 2);
    tick();

    // Holdoff of 10: cycle 0 accepted, cycle 5 lost, cycle 12 accepted
    do_reset();
    holdoff = 10;
    for (int k = 0; k < 15; k++) begin
      trig = (k == 0 || k == 5 || k == 12) ? 4'b0001 : 4'b0000;
      tick();
      trig = '0;
      @(negedge clk250);
      check("ho_digitize", digitize, (k == 0 || k == 12));
    end
    check("ho_lost", lost_count, 1);
    tick();
    holdoff = 0;

    // Source masking and global disable
    do_reset();
    src_en = 4'b1110;
    fire(4'b1011);
    @(negedge clk250);
    check("mask_src", dig_src, 4'b1010);
    tick();
    disable_in = 1'b1;
    fire(4'b1111);
    @(negedge clk250);
    check("dis_digitize", digitize, 0);
    check("dis_lost", lost_count, 0);
    check("dis_dead", dead, 1);
    tick();
    disable_in = 1'b0;
    src_en = '1;

    // Saturation of the lost counter, then clear racing an event
    do_reset();
    for (int i = 0; i < NB; i++) begin
      fire(4'b0001);
      tick();
    end
    trig = 4'b0001;
    repeat (70000) tick();
    @(negedge clk250);
    check("sat_lost", lost_count, 16'hFFFF);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    trig = '0;
    @(negedge clk250);
    check("clr_lost", lost_count, 0);
    tick();

    // Asynchronous reset in the middle of a holdoff
    do_reset();
    fire(4'b0001);
    tick();
    fire(4'b0001);
    tick();
    holdoff = 20;
    fire(4'b0001);
    tick();
    tick();
    check("pre_rst_hold", hold, 4'b0111);
    #2 rst_i = 1'b1;
    #1;
    check("arst_hold", hold, 0);
    check("arst_status", status, 0);
    check("arst_digitize", digitize, 0);
    check("arst_dead", dead, 0);
    tick();
    rst_i = 1'b0;
    holdoff = 0;
    fire(4'b0001);
    @(negedge clk250);
    check("post_rst_buf", dig_buf, 0);
    check("post_rst_digitize", digitize, 1);
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      trig       = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      if ($urandom_range(0, 50) == 0) src_en = NS'($urandom);
      disable_in = ($urandom_range(0, 30) == 0);
      holdoff    = HB'($urandom_range(0, 4));
      clear      = ($urandom_range(0, 3) == 0);
      clear_buf  = BB'($urandom);
      lost_clr   = ($urandom_range(0, 200) == 0);
      tick();
    end
    trig = '0;
    clear = 1'b0;
    lost_clr = 1'b0;
    tick();
    @(negedge clk250);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trigger_buffer_manager_n.md
Name: trigger_buffer_manager_n

Overview:
- Parametrised successor to the fixed 4-buffer / 4-source trigger buffer handler in the TURF trigger interface.
- Accepts NUM_SRC masked trigger sources and allocates one of NUM_BUF digitizer buffers round-robin.
- Drives a per-buffer HOLD and issues a one-cycle digitize command carrying the buffer index and source bitmap.
- New over the previous generation: programmable per-source enable, programmable post-trigger holdoff, and a saturating lost-trigger counter. All logic runs on the clk250 domain.

Parameters:
- NUM_BUF, 4, number of digitizer buffers (2..16).
- BUF_BITS, 2, index width; must equal clog2(NUM_BUF).
- NUM_SRC, 4, number of trigger sources; bit 0 is RF.
- HOLDOFF_BITS, 8, width of the holdoff counter.
- LOST_BITS, 16, width of the lost-trigger counter.

Ports:
- clk250_i  in  1  the block's single clock (250 MHz).
- rst_i  in  1  asynchronous, active-high reset.
- trig_i  in  NUM_SRC  trigger pulses, one cycle each, synchronous to clk250_i.
- src_en_i  in  NUM_SRC  per-source enable; quasi-static.
- disable_i  in  1  global trigger inhibit.
- holdoff_i  in  HOLDOFF_BITS  extra dead cycles after each accepted trigger.
- clear_i  in  1  one-cycle release strobe.
- clear_buffer_i  in  BUF_BITS  buffer to release; qualified by clear_i.
- lost_clr_i  in  1  zeroes lost_count_o.
- digitize_o  out  1  one-cycle digitize command.
- digitize_buffer_o  out  BUF_BITS  buffer being digitized; valid with digitize_o.
- digitize_source_o  out  NUM_SRC  masked sources that fired; valid with digitize_o.
- buffer_status_o  out  NUM_BUF  1 = buffer occupied.
- HOLD_o  out  NUM_BUF  per-buffer hold; equals buffer_status_o.
- dead_o  out  1  block cannot accept a trigger.
- lost_count_o  out  LOST_BITS  count of triggers dropped while dead.

Behaviour:
- Reset (async, immediate):
  - All outputs 0, wr_ptr = 0, FSM = IDLE, holdoff counter = 0.
  - Reset mid-operation discards all occupancy and drops HOLD immediately.
- Trigger qualification: m = trig_i & src_en_i & {NUM_SRC{~disable_i}}. A trigger event is any bit of m set.
- Free buffer: the first index b with buffer_status_o[b] == 0, searching wr_ptr, wr_ptr+1, … modulo NUM_BUF.
- FSM states:
  - IDLE: on an event with a free buffer, go to ISSUE. Capture b and m.
  - ISSUE (1 cycle): assert digitize_o, digitize_buffer_o = b, digitize_source_o = m; set buffer_status_o[b]; wr_ptr <= b+1 (wraps). If holdoff_i == 0, go to IDLE; otherwise load the counter with holdoff_i and go to HOLDOFF.
  - HOLDOFF: decrement each cycle; when the counter reaches 1, go to IDLE.
- Latency and timing:
  - A trigger at cycle N is registered; digitize_o, the status bit and HOLD are high at N+1.
  - The earliest next accepted trigger is at cycle N+2+holdoff_i.
- Simultaneous sources: all fired sources are reported together in one bitmap; only one buffer is used.
- dead_o = (state != IDLE) | (all buffers occupied) | disable_i.
- Lost counter:
  - Increments by 1 on every cycle with an event while state != IDLE or all buffers are full.
  - Events suppressed by disable_i or src_en_i are not counted.
  - Saturates at all-ones. lost_clr_i wins over an increment in the same cycle.
- Clear:
  - clear_i releases clear_buffer_i on the next edge. Clearing an unoccupied buffer is ignored.
  - A clear in the same cycle as ISSUE sets the allocated bit and releases the cleared bit. If both name the same buffer, the set wins.
  - Free-buffer search uses the registered status, so a buffer released at cycle N is allocatable from cycle N+1.
  - clear_buffer_i >= NUM_BUF is ignored.
- Full:
  - Triggers are dropped and counted.
  - The FSM stays in IDLE; the first event after a clear is accepted normally.
- wr_ptr never skips backwards: round-robin order is preserved across clears.

Decomposition:
- Shared package trigger_pkg holds:
  - the source bit positions (SRC_RF = 0, SRC_PPS1 = 1, SRC_PPS2 = 2, SRC_SOFT = 3);
  - the FSM state encoding (IDLE, ISSUE, HOLDOFF);
  - default parameter constants.
- One sub-module is natural: rr_free_finder, a combinational rotate-and-priority-encode over buffer_status given wr_ptr, returning index and found flag.

Test Plan:
- Reset, then pulse trig_i = 4'b0001 with src_en_i = 4'hF and holdoff_i = 0 → one cycle later digitize_o = 1, buffer 0, source 4'b0001, HOLD_o = 4'b0001, lost = 0.
- Four triggers spaced 3 cycles apart, no clears → buffers 0, 1, 2, 3 in order. A fifth trigger → no digitize, dead_o = 1, lost_count_o = 1. Clear buffer 2, trigger again → buffer 2 is used.
- holdoff_i = 10, trig at cycle 0 and at cycles 5 and 12 → only cycle 0 accepted (lost = 1 for the cycle-5 event). Cycle 12 is accepted, digitize at 13.
- trig_i = 4'b1011 with src_en_i = 4'b1110 → digitize_source_o = 4'b1010. With disable_i = 1 → no digitize and lost count unchanged.
- Drive lost events continuously for 70000 cycles with buffers full → lost_count_o holds 16'hFFFF. Assert lost_clr_i alongside an event → 0.
- Assert rst_i mid-HOLDOFF with 3 buffers occupied → outputs 0 asynchronously. The first trigger after release uses buffer 0.
